// File: rtl/idli_pkg.sv
// Shared idli types: core data/counter types plus the retirement trace record.
package idli_pkg;

  localparam int DATA_W      = 16;
  localparam int NUM_REGS    = 16;
  localparam int TRACE_SEQ_W = 16;

  typedef logic [DATA_W-1:0]           data_t;
  typedef logic [1:0]                  ctr_t;
  typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;

  // seq is zero-extended from the block's SEQ_W, so SEQ_W must not exceed TRACE_SEQ_W.
  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    data_t                  pc;
    logic                   gpr_wr;
    reg_idx_t               reg_idx;
    data_t                  reg_data;
    logic                   pred_wr;
    logic                   pred;
  } trace_rec_t;

endpackage

// File: rtl/idli_retire_trace_m_if.sv
// Consumer-side bus of the retirement trace buffer.
interface idli_retire_trace_m_if
  import idli_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OVF_W = 8
) ();

  logic                     o_vld;
  logic                     i_rdy;
  trace_rec_t               o_rec;
  logic [$clog2(DEPTH):0]   o_count;
  logic [OVF_W-1:0]         o_ovf;

  modport master (output o_vld, o_rec, o_count, o_ovf, input i_rdy);
  modport slave  (input o_vld, o_rec, o_count, o_ovf, output i_rdy);

endinterface

// File: rtl/idli_trace_fifo_m.sv
// Circular trace FIFO with registered head read, drop-newest or overwrite-oldest when full.
module idli_trace_fifo_m
  import idli_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int OVERWRITE = 0
) (
  input  logic                   gck,
  input  logic                   rst_n,
  input  logic                   push,
  input  trace_rec_t             din,
  input  logic                   rdy,
  output logic                   vld,
  output trace_rec_t             rec,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf_evt
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nx, rd_nx, count_nx;
  logic        wr_en, rd_adv, pop, full;
  trace_rec_t  head_nx;

  assign pop  = vld && rdy;
  assign full = (count == (AW+1)'(DEPTH));

  always_comb begin
    wr_en   = 1'b0;
    rd_adv  = pop;
    ovf_evt = 1'b0;
    if (push) begin
      if (!full || pop) begin
        wr_en = 1'b1;
      end else begin
        ovf_evt = 1'b1;
        // When full, wr and rd index the same slot: replace head and slide both.
        if (OVERWRITE != 0) begin
          wr_en  = 1'b1;
          rd_adv = 1'b1;
        end
      end
    end
    wr_nx    = wr_en  ? wr_ptr + 1'b1 : wr_ptr;
    rd_nx    = rd_adv ? rd_ptr + 1'b1 : rd_ptr;
    count_nx = count + (AW+1)'(wr_en) - (AW+1)'(rd_adv);
    // Registered head: forward the incoming record if it lands in the next head slot.
    if (count_nx == '0)
      head_nx = '0;
    else if (wr_en && (wr_ptr[AW-1:0] == rd_nx[AW-1:0]))
      head_nx = din;
    else
      head_nx = mem[rd_nx[AW-1:0]];
  end

  always_ff @(posedge gck) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= 1'b0;
      rec    <= '0;
    end else begin
      wr_ptr <= wr_nx;
      rd_ptr <= rd_nx;
      count  <= count_nx;
      vld    <= (count_nx != '0);
      rec    <= head_nx;
    end
  end

endmodule

// File: rtl/idli_retire_trace_m.sv
// Retirement trace: captures one record per retired EX instruction into a drainable FIFO.
module idli_retire_trace_m
  import idli_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int SEQ_W     = 8,
  parameter int OVF_W     = 8,
  parameter int OVERWRITE = 0
) (
  input  logic     gck,
  input  logic     rst_n,
  input  ctr_t     i_ctr,
  input  logic     i_run_instr,
  input  logic     i_skip_instr,
  input  logic     i_enc_vld,
  input  logic     i_enc_new,
  input  data_t    i_pc,
  input  logic     i_dst_reg_wr,
  input  reg_idx_t i_dst_reg,
  input  logic     i_dst_pred,
  input  logic     i_pred,
  output reg_idx_t o_rd_idx,
  input  data_t    i_rd_data,
  idli_retire_trace_m_if.master trc
);

  data_t            pc_pend;
  logic             gpr_wr, prd_wr, done_q, ovf_evt;
  logic [SEQ_W-1:0] seq_q;
  logic [OVF_W-1:0] ovf_q;
  trace_rec_t       rec_in;

  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      pc_pend  <= '0;
      gpr_wr   <= 1'b0;
      prd_wr   <= 1'b0;
      o_rd_idx <= '0;
      done_q   <= 1'b0;
      seq_q    <= '0;
      ovf_q    <= '0;
    end else begin
      // ctr==0 is also the push cycle of the previous instruction; the record
      // below is built from the values held before this update.
      if (i_ctr == '0) begin
        if (i_enc_vld && i_enc_new) pc_pend <= i_pc;
        gpr_wr   <= i_dst_reg_wr;
        o_rd_idx <= i_dst_reg;
        prd_wr   <= i_run_instr && i_dst_pred && !i_skip_instr;
      end
      done_q <= (&i_ctr) && i_run_instr;
      if (done_q) seq_q <= seq_q + 1'b1;
      if (ovf_evt && !(&ovf_q)) ovf_q <= ovf_q + 1'b1;
    end
  end

  always_comb begin
    rec_in          = '0;
    rec_in.seq      = TRACE_SEQ_W'(seq_q);
    rec_in.pc       = pc_pend;
    rec_in.gpr_wr   = gpr_wr;
    rec_in.reg_idx  = o_rd_idx;
    rec_in.reg_data = gpr_wr ? i_rd_data : '0;
    rec_in.pred_wr  = prd_wr;
    rec_in.pred     = i_pred;
  end

  idli_trace_fifo_m #(
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .gck     (gck),
    .rst_n   (rst_n),
    .push    (done_q),
    .din     (rec_in),
    .rdy     (trc.i_rdy),
    .vld     (trc.o_vld),
    .rec     (trc.o_rec),
    .count   (trc.o_count),
    .ovf_evt (ovf_evt)
  );

  assign trc.o_ovf = ovf_q;

endmodule

// File: doc/idli_retire_trace_m.md
# idli_retire_trace_m

Parametrised retirement trace buffer for the idli core. Observes the execution unit's 4-GCK sync counter and instruction handshake signals, builds one record per retired instruction (PC, destination register write, predicate write, sequence number), and queues records in a DEPTH-entry FIFO drained by a valid/ready consumer. It replaces ad-hoc per-cycle sampling in benches and adds configurable depth, an overflow policy and drop accounting. It sits beside `idli_top_m`, with its inputs taken from the EX stage.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- SEQ_W, 8: sequence-number width; wraps modulo 2^SEQ_W.
- OVF_W, 8: overflow-counter width; saturating.
- OVERWRITE, 0: 0 drops the newest record when full; 1 overwrites the oldest.

Ports:
- gck  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_ctr  in  ctr_t  EX sync counter; 0..3 per 4-GCK period.
- i_run_instr  in  1  instruction executing this period.
- i_skip_instr  in  1  instruction predicated off.
- i_enc_vld, i_enc_new  in  1 each  encoding valid, and new in EX.
- i_pc  in  data_t  current PC.
- i_dst_reg_wr  in  1  GPR write this instruction.
- i_dst_reg  in  reg_idx_t  destination register index.
- i_dst_pred  in  1  destination is the predicate register.
- i_pred  in  1  predicate register value.
- o_rd_idx  out  reg_idx_t  register index the block is reading; reset 0.
- i_rd_data  in  data_t  value of register `o_rd_idx`; combinational from the RF.
- o_vld  out  1  head record valid; reset 0.
- i_rdy  in  1  consumer accepts the head record.
- o_rec  out  trace_rec_t  head record; all-zero when `o_vld` is 0.
- o_count  out  $clog2(DEPTH)+1  occupancy; reset 0.
- o_ovf  out  OVF_W  records lost; reset 0.

## Operation
Capture, evaluated per period:
- PC latch. At `ctr==0`, if `i_enc_vld && i_enc_new`, latch `i_pc` into `pc_pend`.
- Destination latch. At `ctr==0`, latch `gpr_wr = i_dst_reg_wr`, `o_rd_idx = i_dst_reg`, and `prd_wr = i_run_instr && i_dst_pred && !i_skip_instr`.
- Retire detect. At `&i_ctr && i_run_instr`, set `done_q`.
- Push. The cycle `done_q` is 1 (the next `ctr==0`) is the push cycle.
  - The block forms a record from `pc_pend`, `gpr_wr`, `o_rd_idx`, `i_rd_data` (sampled this cycle), `prd_wr`, `i_pred` and `seq_q`.
  - It then pushes the record and increments `seq_q`.
  - The destination latch for the following instruction updates on the same edge; the record uses the pre-update values.
- A skipped instruction still retires and still produces a record.

Record (`trace_rec_t`): seq, pc, gpr_wr, reg idx, reg data, pred_wr, pred value. Reg data is 0 when `gpr_wr` is 0.

FIFO:
- Circular buffer with read/write pointers of $clog2(DEPTH) bits plus a wrap bit.
- Pop when `o_vld && i_rdy`.
- No bypass: a record pushed into an empty FIFO becomes visible the next cycle.

Boundary rules:
- Full, push, no pop, OVERWRITE=0: the record is discarded, `o_ovf` increments and `seq_q` still increments, so the consumer sees a sequence gap.
- Full, push, no pop, OVERWRITE=1: the head entry is replaced and both pointers advance. `o_ovf` increments and `o_count` stays at DEPTH.
- Full, push and pop together: both are accepted with no overflow and `o_count` unchanged.
- Empty with `i_rdy` high: no pop and no pointer change.
- `o_ovf` saturates at all ones.
- `seq_q` wraps from 2^SEQ_W-1 to 0.
- Reset mid-operation clears pointers, `o_count`, `o_ovf`, `seq_q`, `pc_pend`, `done_q` and both latches. Any partially observed instruction is lost; the first record after reset has seq 0.

## Timing
- Retirement to push: 1 cycle (`done_q`). Push to `o_vld`: 1 cycle. Total: 2 GCK after the `ctr==3` retire cycle.
- `o_rec`, `o_vld` and `o_count` are registered outputs; `o_rec` is a registered read of the head entry.
- Maximum push rate is 1 per 4 GCK; pop rate is up to 1 per GCK.
- `i_rd_data` is combinational from `o_rd_idx` and is sampled only in the push cycle.

## Structure
- Shared package `idli_pkg` gets:
  - `trace_rec_t` (packed struct),
  - `reg_idx_t` = logic [$clog2(NUM_REGS)-1:0].
- `data_t` and `ctr_t` already live in `idli_pkg`.
- One natural sub-module: `idli_trace_fifo_m`, the parametrised FIFO with overwrite mode, pointers and count.
- Capture logic and counters stay in the top module.

## Test plan
- Reset, then one GPR write at PC 0x0010 writing r3=0xBEEF: one record with seq 0, pc 0x0010, gpr_wr 1, idx 3, data 0xBEEF, pred_wr 0; `o_vld` rises 2 GCK after the `ctr==3` retire cycle.
- Predicated-off compare targeting P: record has pred_wr 0 and gpr_wr 0, seq still increments.
- DEPTH=4, OVERWRITE=0, `i_rdy`=0, 6 retirements: `o_count`=4, `o_ovf`=2; draining yields seq 0,1,2,3.
- DEPTH=4, OVERWRITE=1, same stimulus: `o_ovf`=2; draining yields seq 2,3,4,5.
- FIFO full with `i_rdy`=1 held during a push cycle: no overflow, `o_count` stays 4, next drained seq is contiguous.
- Assert rst_n mid-period (ctr=2) while FIFO holds 3 records: all outputs are 0 immediately; the next retirement produces seq 0.
